// File: rtl/p_common.sv
// p_common: shared execute-stage types for the shift unit.
// Shift encodings, request bundle and stage-split helpers.
package p_common;

  typedef enum logic [2:0] {
    SHIFT_SHL     = 3'd0,
    SHIFT_SHR     = 3'd1,
    SHIFT_ASL     = 3'd2,
    SHIFT_ASR     = 3'd3,
    SHIFT_ROL     = 3'd4,
    SHIFT_ROR     = 3'd5,
    SHIFT_INVALID = 3'd6
  } e_shift_type;

  localparam int SHIFT_TAG_W = 5;
  // Sized for the widest supported datapath (64 bits).
  localparam int SHIFT_AMT_W = 6;

  typedef struct packed {
    e_shift_type            op;
    logic [SHIFT_AMT_W-1:0] amount;
    logic [SHIFT_TAG_W-1:0] tag;
  } s_shift_req;

  function automatic logic shift_illegal(logic [2:0] op);
    return (op == SHIFT_INVALID) || (op == 3'b111);
  endfunction

  // Earlier stages take the extra barrel level.
  function automatic int level_first(int s, int levels, int stages);
    int base;
    int extra;
    base  = levels / stages;
    extra = levels % stages;
    return s * base + ((s < extra) ? s : extra);
  endfunction

  function automatic int level_stage(int k, int levels, int stages);
    int st;
    st = 0;
    for (int s = 0; s < stages; s++)
      if (level_first(s, levels, stages) <= k) st = s;
    return st;
  endfunction

endpackage

// File: rtl/shift_unit_level.sv
// shift_level: one combinational barrel level at distance DIST.
// Carry tracking only exists with SHIFT_UNIT_CARRY_EN.
module shift_level
  import p_common::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [2:0]       op,
  input  logic             apply,
  input  logic             sign,
  input  logic [WIDTH-1:0] data,
  input  logic             ovf,
`ifdef SHIFT_UNIT_CARRY_EN
  input  logic             carry,
  output logic             carry_next,
`endif
  output logic [WIDTH-1:0] shifted,
  output logic             ovf_next
);

  logic [WIDTH-1:0] moved;
  logic             fill;
  logic             lost;

  always_comb begin
    fill  = (op == SHIFT_ASR) & data[WIDTH-1];
    moved = data;
    unique case (op)
      SHIFT_SHL, SHIFT_ASL:
        moved = data << DIST;
      SHIFT_SHR, SHIFT_ASR:
        moved = {{DIST{fill}}, data[WIDTH-1:DIST]};
      SHIFT_ROL:
        moved = {data[WIDTH-1-DIST:0],
                 data[WIDTH-1:WIDTH-DIST]};
      SHIFT_ROR:
        moved = {data[DIST-1:0], data[WIDTH-1:DIST]};
      default:
        moved = data;
    endcase
    // Any departed bit or the new sign must match the original sign.
    lost = (|(data[WIDTH-1:WIDTH-DIST] ^ {DIST{sign}}))
         | (data[WIDTH-1-DIST] ^ sign);
    shifted  = apply ? moved : data;
    ovf_next = ovf | (apply & (op == SHIFT_ASL) & lost);
  end

`ifdef SHIFT_UNIT_CARRY_EN
  logic left;

  always_comb begin
    left = (op == SHIFT_SHL) || (op == SHIFT_ASL)
        || (op == SHIFT_ROL);
    if (!apply)    carry_next = carry;
    else if (left) carry_next = data[WIDTH-DIST];
    else           carry_next = data[DIST-1];
  end
`endif

endmodule

// File: rtl/shift_unit.sv
// shift_unit: pipelined barrel shift/rotate, valid/ready handshake.
// Define SHIFT_UNIT_CARRY_EN to add out_carry.
module shift_unit
  import p_common::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int AMT_W  = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [AMT_W-1:0]       in_amount,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SHIFT_TAG_W-1:0] in_tag,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SHIFT_TAG_W-1:0] out_tag,
  output logic                   out_ovf,
  output logic                   out_err
`ifdef SHIFT_UNIT_CARRY_EN
  ,
  output logic                   out_carry
`endif
);

  localparam int LEVELS = $clog2(WIDTH);

  logic             adv      [STAGES+1];
  logic             st_valid [STAGES];
  logic [WIDTH-1:0] st_data  [STAGES];
  s_shift_req       st_req   [STAGES];
  logic             st_sign  [STAGES];
  logic             st_ovf   [STAGES];
  logic             st_err   [STAGES];

  logic             src_valid [STAGES];
  logic [WIDTH-1:0] src_data  [STAGES];
  s_shift_req       src_req   [STAGES];
  logic             src_sign  [STAGES];
  logic             src_ovf   [STAGES];
  logic             src_err   [STAGES];

  logic [WIDTH-1:0] lv_data [LEVELS];
  logic             lv_ovf  [LEVELS];

`ifdef SHIFT_UNIT_CARRY_EN
  logic st_carry  [STAGES];
  logic src_carry [STAGES];
  logic lv_carry  [LEVELS];
`endif

  // Stall propagates back from the consumer; bubbles collapse.
  always_comb begin
    adv[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--)
      adv[s] = !st_valid[s] || adv[s+1];
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int S =
      level_stage(k, LEVELS, STAGES);
    localparam bit HEAD =
      (level_first(S, LEVELS, STAGES) == k);

    logic [WIDTH-1:0] d;
    logic             o;
`ifdef SHIFT_UNIT_CARRY_EN
    logic             c;
`endif

    if (HEAD) begin : g_head
      assign d = src_data[S];
      assign o = src_ovf[S];
`ifdef SHIFT_UNIT_CARRY_EN
      assign c = src_carry[S];
`endif
    end else begin : g_chain
      assign d = lv_data[k-1];
      assign o = lv_ovf[k-1];
`ifdef SHIFT_UNIT_CARRY_EN
      assign c = lv_carry[k-1];
`endif
    end

    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_level (
      .op         (src_req[S].op),
      .apply      (src_req[S].amount[k]),
      .sign       (src_sign[S]),
      .data       (d),
      .ovf        (o),
`ifdef SHIFT_UNIT_CARRY_EN
      .carry      (c),
      .carry_next (lv_carry[k]),
`endif
      .shifted    (lv_data[k]),
      .ovf_next   (lv_ovf[k])
    );
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LAST =
      level_first(s + 1, LEVELS, STAGES) - 1;

    if (s == 0) begin : g_src_in
      logic bad_op;
      assign bad_op       = shift_illegal(in_op);
      assign src_valid[0] = in_valid;
      assign src_err[0]   = bad_op;
      assign src_req[0]   = '{
        op:     bad_op ? SHIFT_INVALID
                       : e_shift_type'(in_op),
        amount: SHIFT_AMT_W'(in_amount),
        tag:    in_tag
      };
      // Illegal ops shift zero, so data, ovf and carry stay 0.
      assign src_data[0]  = bad_op ? '0 : in_data;
      assign src_sign[0]  = in_data[WIDTH-1];
      assign src_ovf[0]   = 1'b0;
`ifdef SHIFT_UNIT_CARRY_EN
      assign src_carry[0] = 1'b0;
`endif
    end else begin : g_src_reg
      assign src_valid[s] = st_valid[s-1];
      assign src_err[s]   = st_err[s-1];
      assign src_req[s]   = st_req[s-1];
      assign src_data[s]  = st_data[s-1];
      assign src_sign[s]  = st_sign[s-1];
      assign src_ovf[s]   = st_ovf[s-1];
`ifdef SHIFT_UNIT_CARRY_EN
      assign src_carry[s] = st_carry[s-1];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_valid[s] <= 1'b0;
        st_data[s]  <= '0;
        st_req[s]   <= '0;
        st_sign[s]  <= 1'b0;
        st_ovf[s]   <= 1'b0;
        st_err[s]   <= 1'b0;
`ifdef SHIFT_UNIT_CARRY_EN
        st_carry[s] <= 1'b0;
`endif
      end else begin
        if (flush)
          st_valid[s] <= 1'b0;
        else if (adv[s])
          st_valid[s] <= src_valid[s];
        if (adv[s] && src_valid[s]) begin
          st_data[s]  <= lv_data[LAST];
          st_req[s]   <= src_req[s];
          st_sign[s]  <= src_sign[s];
          st_ovf[s]   <= lv_ovf[LAST];
          st_err[s]   <= src_err[s];
`ifdef SHIFT_UNIT_CARRY_EN
          st_carry[s] <= lv_carry[LAST];
`endif
        end
      end
    end
  end

  assign out_valid = st_valid[STAGES-1];
  assign out_data  = st_data[STAGES-1];
  assign out_tag   = st_req[STAGES-1].tag;
  assign out_ovf   = st_ovf[STAGES-1];
  assign out_err   = st_err[STAGES-1];
`ifdef SHIFT_UNIT_CARRY_EN
  assign out_carry = st_carry[STAGES-1];
`endif

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: vector table, directed corners and random ops
// against an arithmetic reference model and in-order scoreboard.
module tb_shift_unit;
  import p_common::*;

  localparam int W  = 32;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [4:0]    in_amount;
  logic [W-1:0]  in_data;
  logic [4:0]    in_tag;
  logic          flush;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [4:0]    out_tag;
  logic          out_ovf;
  logic          out_err;
`ifdef SHIFT_UNIT_CARRY_EN
  logic          out_carry;
`endif

  shift_unit #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_amount (in_amount),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
`ifdef SHIFT_UNIT_CARRY_EN
    ,
    .out_carry (out_carry)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        ovf;
    logic        err;
    logic        carry;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  amt;
    logic [31:0] data;
    logic [31:0] rd;
    logic        ovf;
    logic        err;
    logic        carry;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  exp_t sb [$];
  logic [4:0] got [$];
  bit   collect = 0;
  int   rmode = 0;
  logic rfix = 1'b1;
  logic [3:0] pat = 4'b1001;
  int   pidx = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the spec rules.
  function automatic exp_t model(input logic [2:0] op,
                                 input int n, input logic [31:0] d,
                                 input logic [4:0] tag);
    exp_t e;
    logic [63:0] dd;
    logic [63:0] t;
    longint sd;
    e.tag = tag; e.data = d; e.ovf = 0; e.err = 0; e.carry = 0;
    if (op >= 3'd6) begin
      e.data = 0; e.err = 1;
      return e;
    end
    if (n == 0) return e;
    dd = {d, d};
    case (op)
      SHIFT_SHL, SHIFT_ASL: begin
        e.data = d << n;
        e.carry = d[32-n];
        if (op == SHIFT_ASL) begin
          sd = longint'($signed(d)) <<< n;
          e.ovf = (sd != longint'($signed(e.data)));
        end
      end
      SHIFT_SHR: begin
        e.data = d >> n; e.carry = d[n-1];
      end
      SHIFT_ASR: begin
        e.data = $signed(d) >>> n; e.carry = d[n-1];
      end
      SHIFT_ROL: begin
        t = dd << n; e.data = t[63:32]; e.carry = e.data[0];
      end
      default: begin
        t = dd >> n; e.data = t[31:0]; e.carry = e.data[31];
      end
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    #2;
    case (rmode)
      0: out_ready = rfix;
      1: begin
        out_ready = pat[pidx];
        pidx = (pidx + 1) % 4;
      end
      default: out_ready = ($urandom % 4) != 0;
    endcase
  end

  // Scoreboard and handshake monitor, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) sb.delete();
    else begin
      total++;
      if (in_ready !== !(sb.size() == ST && !out_ready)) begin
        bad++;
        $display("FAIL in_ready actual=%b required=%b",
                 in_ready, !(sb.size() == ST && !out_ready));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out actual=tag%0d required=none",
                   out_tag);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_tag", 32'(out_tag), 32'(e.tag));
          chk("sb_ovf", 32'(out_ovf), 32'(e.ovf));
          chk("sb_err", 32'(out_err), 32'(e.err));
`ifdef SHIFT_UNIT_CARRY_EN
          chk("sb_carry", 32'(out_carry), 32'(e.carry));
`endif
          if (collect) got.push_back(out_tag);
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready)
        sb.push_back(model(in_op, int'(in_amount), in_data, in_tag));
    end
  end

  task automatic send(input logic [2:0] op, input logic [4:0] amt,
                      input logic [31:0] d, input logic [4:0] tag);
    bit ok;
    int w;
    w = 0;
    in_valid = 1; in_op = op; in_amount = amt;
    in_data = d; in_tag = tag;
    do begin
      #5 ok = in_ready;
      @(posedge clk); #1;
      w++;
    end while (!ok && w < 50);
    in_valid = 0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout actual=stalled required=accept");
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && sb.size() != 0; c++)
      @(posedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vec_t vt [13];
    bit seen;

    vt[0]  = '{SHIFT_ASR, 5'd4,  32'h80000010, 32'hF8000001,
               1'b0, 1'b0, 1'b0};
    vt[1]  = '{SHIFT_ASL, 5'd1,  32'h40000000, 32'h80000000,
               1'b1, 1'b0, 1'b0};
    vt[2]  = '{SHIFT_SHL, 5'd1,  32'h40000000, 32'h80000000,
               1'b0, 1'b0, 1'b0};
    vt[3]  = '{SHIFT_ROR, 5'd1,  32'h00000001, 32'h80000000,
               1'b0, 1'b0, 1'b1};
    vt[4]  = '{SHIFT_ROL, 5'd0,  32'h12345678, 32'h12345678,
               1'b0, 1'b0, 1'b0};
    vt[5]  = '{3'b110,    5'd5,  32'hFFFFFFFF, 32'h00000000,
               1'b0, 1'b1, 1'b0};
    vt[6]  = '{3'b111,    5'd3,  32'h00000001, 32'h00000000,
               1'b0, 1'b1, 1'b0};
    vt[7]  = '{SHIFT_SHR, 5'd31, 32'hC0000000, 32'h00000001,
               1'b0, 1'b0, 1'b1};
    vt[8]  = '{SHIFT_ASL, 5'd31, 32'hFFFFFFFF, 32'h80000000,
               1'b0, 1'b0, 1'b1};
    vt[9]  = '{SHIFT_ROL, 5'd4,  32'h80000001, 32'h00000018,
               1'b0, 1'b0, 1'b0};
    vt[10] = '{SHIFT_ASL, 5'd31, 32'h00000001, 32'h80000000,
               1'b1, 1'b0, 1'b0};
    vt[11] = '{SHIFT_ASR, 5'd31, 32'h7FFFFFFF, 32'h00000000,
               1'b0, 1'b0, 1'b1};
    vt[12] = '{SHIFT_ASL, 5'd0,  32'h80000000, 32'h80000000,
               1'b0, 1'b0, 1'b0};

    rst = 1; in_valid = 0; flush = 0;
    in_op = 0; in_amount = 0; in_data = 0; in_tag = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    rst = 0;
    @(negedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Table vectors with latency check on each.
    for (int i = 0; i < 13; i++) begin
      send(vt[i].op, vt[i].amt, vt[i].data, 5'(i));
      for (int k = 1; k <= ST; k++) begin
        @(negedge clk); #1;
        chk("latency", 32'(out_valid), 32'(k == ST));
      end
      seen = out_valid;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk); #1;
        seen = out_valid;
      end
      if (!seen) begin
        total++; bad++;
        $display("FAIL vec_timeout actual=none required=vec%0d", i);
      end else begin
        chk("vec_data", out_data, vt[i].rd);
        chk("vec_tag", 32'(out_tag), i);
        chk("vec_ovf", 32'(out_ovf), 32'(vt[i].ovf));
        chk("vec_err", 32'(out_err), 32'(vt[i].err));
`ifdef SHIFT_UNIT_CARRY_EN
        chk("vec_carry", 32'(out_carry), 32'(vt[i].carry));
`endif
      end
      @(posedge clk); #1;
    end

    // Back-to-back with out_ready pattern 1,0,0,1.
    got.delete(); collect = 1; pidx = 0; rmode = 1;
    for (int t = 1; t <= 8; t++)
      send(SHIFT_SHL, 5'(t), $urandom, 5'(t));
    drain();
    collect = 0; rmode = 0; rfix = 1;
    chk("order_count", 32'(got.size()), 32'd8);
    for (int t = 0; t < got.size(); t++)
      chk("order_tag", 32'(got[t]), t + 1);
    @(posedge clk); #1;

    // Flush with pipe full, one op stalled, one offered.
    rfix = 0;
    @(posedge clk); #1;
    send(SHIFT_ROL, 5'd3, 32'hA5A5A5A5, 5'd20);
    send(SHIFT_SHR, 5'd2, 32'h0000F000, 5'd21);
    in_valid = 1; in_op = SHIFT_SHL; in_amount = 1;
    in_data = 32'h1; in_tag = 5'd22;
    @(posedge clk); #1;
    in_tag = 5'd23; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0; rfix = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      chk("flush_no_out", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(SHIFT_ROR, 5'd8, 32'h000000AB, 5'd24);
    for (int k = 1; k <= ST; k++) begin
      @(negedge clk); #1;
      chk("flush_latency", 32'(out_valid), 32'(k == ST));
    end
    chk("flush_next_data", out_data, 32'hAB000000);
    @(posedge clk); #1;

    // Asynchronous reset mid-stream.
    rfix = 0;
    @(posedge clk); #1;
    send(SHIFT_SHL, 5'd1, 32'h0000FFFF, 5'd3);
    send(SHIFT_SHL, 5'd1, 32'h0000FFFF, 5'd4);
    @(negedge clk); #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_tag", 32'(out_tag), 32'd0);
    chk("arst_ovf_err", {out_ovf, out_err}, 32'd0);
    @(posedge clk); #1;
    rst = 0; rfix = 1;
    @(negedge clk); #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Random ops with random back-pressure and gaps.
    rmode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) begin
        @(posedge clk); #1;
      end
      send(3'($urandom % 8), 5'($urandom % 32),
           $urandom, 5'($urandom % 32));
    end
    rmode = 0; rfix = 1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
